pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the five-stage MIPS32 pipeline.
- Takes stall requests from ID, EX and MEM, plus exception/ERET requests from MEM.
- Drives the per-stage stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb, plus the flush strobe and redirect PC.
- Maintains a stall watchdog and performance counters.

Parameters:
- EXC_VECTOR, 32'h0000_0020, redirect PC for every exception except ERET.
- STALL_TIMEOUT, 16'd1024, consecutive stalled cycles before the watchdog fires.
- ERET_CODE, 32'h0000_000E, excp_type value that selects cp0_epc as the redirect.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-low
- stallreq_id  in  1  load-use hazard in ID
- stallreq_ex  in  1  multi-cycle EX op (div/madd) busy
- stallreq_mem  in  1  data memory wait
- excp_req  in  1  MEM-stage exception/ERET commit
- excp_type  in  32  cause code accompanying excp_req
- cp0_epc  in  32  current EPC
- stall  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb
- flush  out  1  clear all pipeline registers this edge
- new_pc  out  32  redirect target, valid when flush=1
- stall_timeout  out  1  sticky watchdog flag
- stall_cnt  out  32  saturating count of stalled cycles
- flush_cnt  out  16  wrapping count of flushes

Behaviour:
- Reset (rst=0, async) values:
  - stall=6'b000000, flush=0, new_pc=0, stall_timeout=0, stall_cnt=0, flush_cnt=0.
  - Watchdog counter=0, state=RUN.
- FSM states: RUN, STALL, RECOVER. Registered state; outputs are combinational from state plus inputs.
- Priority: excp_req > stallreq_mem > stallreq_ex > stallreq_id.
- Flush:
  - In any state, excp_req=1 gives flush=1 and stall=0 in the same cycle.
  - new_pc=cp0_epc when excp_type==ERET_CODE, else EXC_VECTOR.
  - At the next edge: state→RECOVER, flush_cnt+1 (wraps at 16'hFFFF→0), watchdog counter cleared, stall_timeout cleared.
- Stall vector when excp_req=0:
  - stallreq_mem gives 6'b011111.
  - stallreq_ex gives 6'b001111.
  - stallreq_id gives 6'b000111, except in RECOVER, where stallreq_id is masked (its EX-stage compare source was just flushed).
  - No request gives 6'b000000.
- Bubble rule (implemented in the pipeline registers): if stall[n]=1 and stall[n+1]=0, stage n+1 loads a NOP. This block only guarantees the vector is always of the form 0…01…1.
- Transitions:
  - RUN→STALL when any effective stall bit is 1.
  - STALL→RUN when none is 1.
  - RECOVER→STALL or RUN after exactly one cycle, by the same rule.
  - excp_req overrides every transition, sending the FSM to RECOVER.
- stall_cnt: +1 on each edge where stall[0]=1; saturates at 32'hFFFF_FFFF.
- Watchdog:
  - Counts consecutive edges with stall[0]=1 and clears on any edge with stall[0]=0.
  - When it reaches STALL_TIMEOUT, stall_timeout is set. The flag is sticky until flush or reset.
  - The counter holds at STALL_TIMEOUT (no wrap).
  - Stalls are never broken by the watchdog; it is diagnostic only.
- Reset asserted mid-stall or mid-flush returns everything to reset values immediately. Deassertion takes effect at the next edge.

Decomposition:
- Shared package/define file holds:
  - stall bit indices (STALL_PC … STALL_WB)
  - stall vector encodings (StallNone, StallId, StallEx, StallMem)
  - FSM state encodings
  - ERET_CODE and EXC_VECTOR defaults
- One sub-module, stall_watchdog: consecutive-cycle counter, sticky flag, clear input.

Test Plan:
- Reset → all outputs 0. Release reset, no requests, 10 cycles → stall=000000, stall_cnt=0.
- stallreq_ex high 3 cycles → stall=001111 for 3 cycles, stall_cnt=3, state returns to RUN.
- stallreq_id and stallreq_mem together → stall=011111.
- excp_req with excp_type=5 while stallreq_mem=1 → flush=1, stall=000000, new_pc=32'h20, flush_cnt=1.
- ERET: excp_req, excp_type=ERET_CODE, cp0_epc=32'h0000_1234 → new_pc=32'h1234. Next cycle stallreq_id=1 → stall=000000 (RECOVER mask). Following cycle → stall=000111.
- STALL_TIMEOUT=4: stallreq_mem held 6 cycles → stall_timeout=1 after the 4th edge and stays 1. Then excp_req → stall_timeout=0. Drive rst low mid-stall → outputs 0 without a clock edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

   localparam int STALL_PC  = 0;
   localparam int STALL_IF  = 1;
   localparam int STALL_ID  = 2;
   localparam int STALL_EX  = 3;
   localparam int STALL_MEM = 4;
   localparam int STALL_WB  = 5;

   localparam logic [5:0] StallNone = 6'b000000;
   localparam logic [5:0] StallId   = 6'b000111;
   localparam logic [5:0] StallEx   = 6'b001111;
   localparam logic [5:0] StallMem  = 6'b011111;

   localparam logic [31:0] ERET_CODE_DEF  = 32'h0000_000E;
   localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_STALL   = 2'd1,
      ST_RECOVER = 2'd2
   } pipe_state_t;

   // Deepest requesting stage wins; the result is always a 0...01...1 thermometer.
   function automatic logic [5:0] stall_encode(input logic req_mem, input logic req_ex,
                                               input logic req_id, input logic id_mask);
      logic [5:0] vec;
      vec = StallNone;
      if (req_mem)
         vec = StallMem;
      else if (req_ex)
         vec = StallEx;
      else if (req_id && !id_mask)
         vec = StallId;
      return vec;
   endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// rtl/pipe_ctrl_stall_watchdog.sv - consecutive-stall counter with sticky timeout flag
module stall_watchdog #(
   parameter logic [15:0] TIMEOUT = 16'd1024
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic clear,
   output logic timeout
);

   logic [15:0] run_cnt;

   // Counter parks at TIMEOUT so a very long stall cannot wrap and re-arm.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_cnt <= '0;
         timeout <= 1'b0;
      end else if (clear) begin
         run_cnt <= '0;
         timeout <= 1'b0;
      end else if (active) begin
         if (run_cnt != TIMEOUT)
            run_cnt <= run_cnt + 16'd1;
         if (run_cnt == TIMEOUT - 16'd1)
            timeout <= 1'b1;
      end else begin
         run_cnt <= '0;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall vector, flush strobe and redirect PC for the 5-stage pipeline
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEF,
   parameter logic [15:0] STALL_TIMEOUT = 16'd1024,
   parameter logic [31:0] ERET_CODE     = ERET_CODE_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic        excp_req,
   input  logic [31:0] excp_type,
   input  logic [31:0] cp0_epc,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        stall_timeout,
   output logic [31:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   pipe_state_t state;
   pipe_state_t next_state;

   // Outputs are gated by rst so an asserted reset forces them low without an edge.
   always_comb begin
      stall      = StallNone;
      flush      = 1'b0;
      new_pc     = '0;
      next_state = state;
      if (rst) begin
         if (excp_req) begin
            flush      = 1'b1;
            new_pc     = (excp_type == ERET_CODE) ? cp0_epc : EXC_VECTOR;
            next_state = ST_RECOVER;
         end else begin
            // ID's hazard compare used the EX stage that the last flush just cleared.
            stall      = stall_encode(stallreq_mem, stallreq_ex, stallreq_id,
                                      state == ST_RECOVER);
            next_state = (stall != StallNone) ? ST_STALL : ST_RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_RUN;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= next_state;
         if (stall[STALL_PC] && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
         if (flush)
            flush_cnt <= flush_cnt + 16'd1;
      end
   end

   stall_watchdog #(
      .TIMEOUT(STALL_TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .active (stall[STALL_PC]),
      .clear  (flush),
      .timeout(stall_timeout)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with a behavioural reference model
module tb_pipe_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0, excp_req = 1'b0;
   logic [31:0] excp_type = '0, cp0_epc = '0;
   logic [5:0]  stall;
   logic        flush, stall_timeout;
   logic [31:0] new_pc, stall_cnt;
   logic [15:0] flush_cnt;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit          m_recover;
   int          m_consec;
   bit          m_to;
   longint      m_scnt;
   int          m_fcnt;
   logic [5:0]  e_stall;
   logic        e_flush;
   logic [31:0] e_pc;

   always #5 clk = ~clk;

   pipe_ctrl #(
      .EXC_VECTOR(32'h0000_0020), .STALL_TIMEOUT(16'(TO)), .ERET_CODE(32'h0000_000E)
   ) dut (
      .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
      .stallreq_mem(stallreq_mem), .excp_req(excp_req), .excp_type(excp_type),
      .cp0_epc(cp0_epc), .stall(stall), .flush(flush), .new_pc(new_pc),
      .stall_timeout(stall_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   function automatic void model_comb();
      int depth;
      depth = 0;
      e_flush = rst && excp_req;
      if (rst && !excp_req) begin
         if (stallreq_mem) depth = 5;
         else if (stallreq_ex) depth = 4;
         else if (stallreq_id && !m_recover) depth = 3;
      end
      e_stall = 6'((1 << depth) - 1);
      e_pc = !e_flush ? 32'h0 : (excp_type == 32'hE ? cp0_epc : 32'h20);
   endfunction

   function automatic void model_reset();
      m_recover = 0; m_consec = 0; m_to = 0; m_scnt = 0; m_fcnt = 0;
   endfunction

   function automatic void model_edge();
      if (!rst) begin
         model_reset();
         return;
      end
      if (e_stall[0] && m_scnt < 64'hFFFF_FFFF) m_scnt++;
      if (e_flush) begin
         m_consec = 0; m_to = 0; m_fcnt = (m_fcnt + 1) % 65536;
      end else if (e_stall[0]) begin
         if (m_consec < TO) m_consec++;
         if (m_consec == TO) m_to = 1;
      end else begin
         m_consec = 0;
      end
      m_recover = e_flush;
   endfunction

   task automatic drive(input bit id, input bit ex, input bit mem, input bit exc,
                        input logic [31:0] typ, input logic [31:0] epc);
      stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
      excp_req = exc; excp_type = typ; cp0_epc = epc;
      #1;
      model_comb();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_edge();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      tick();
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(1, 1, 1, 0, 0, 0);
      checks++;
      if (stall !== 6'b0 || flush !== 1'b0 || new_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_comb stall=%b flush=%b new_pc=%h, want 0/0/0", stall, flush, new_pc);
      end
      model_reset();
      tick();
      checks++;
      if (stall_timeout !== 1'b0 || stall_cnt !== 32'h0 || flush_cnt !== 16'h0) begin
         errors++;
         $display("FAIL reset_regs to=%b scnt=%0d fcnt=%0d, want 0/0/0", stall_timeout, stall_cnt, flush_cnt);
      end
      rst = 1'b1;
      #1;
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 0, 0, 0, 0);
         checks++;
         if (stall !== 6'b000000) begin
            errors++;
            $display("FAIL idle_stall cyc%0d got %b want 000000", i, stall);
         end
         tick();
      end
      checks++;
      if (stall_cnt !== 32'd0) begin
         errors++;
         $display("FAIL idle_stall_cnt got %0d want 0", stall_cnt);
      end
   endtask

   task automatic test_ex_stall();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0, 0, 0);
         checks++;
         if (stall !== 6'b001111) begin
            errors++;
            $display("FAIL ex_stall cyc%0d got %b want 001111", i, stall);
         end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      checks++;
      if (stall_cnt !== 32'd3 || stall !== 6'b000000) begin
         errors++;
         $display("FAIL ex_stall_done scnt=%0d stall=%b want 3/000000", stall_cnt, stall);
      end
      tick();
      // back in RUN: an ID hazard is not masked
      drive(1, 0, 0, 0, 0, 0);
      checks++;
      if (stall !== 6'b000111) begin
         errors++;
         $display("FAIL ex_then_id got %b want 000111", stall);
      end
      tick();
   endtask

   task automatic test_combined();
      do_reset();
      drive(1, 0, 1, 0, 0, 0);
      checks++;
      if (stall !== 6'b011111) begin
         errors++;
         $display("FAIL id_mem got %b want 011111", stall);
      end
      tick();
   endtask

   task automatic test_exception();
      do_reset();
      drive(0, 0, 1, 1, 32'd5, 32'hDEAD_BEEF);
      checks++;
      if (flush !== 1'b1 || stall !== 6'b000000 || new_pc !== 32'h20) begin
         errors++;
         $display("FAIL excp flush=%b stall=%b new_pc=%h want 1/000000/00000020", flush, stall, new_pc);
      end
      tick();
      checks++;
      if (flush_cnt !== 16'd1) begin
         errors++;
         $display("FAIL excp_flush_cnt got %0d want 1", flush_cnt);
      end
   endtask

   task automatic test_eret();
      do_reset();
      drive(0, 0, 0, 1, 32'h0000_000E, 32'h0000_1234);
      checks++;
      if (flush !== 1'b1 || new_pc !== 32'h0000_1234) begin
         errors++;
         $display("FAIL eret flush=%b new_pc=%h want 1/00001234", flush, new_pc);
      end
      tick();
      drive(1, 0, 0, 0, 0, 0);
      checks++;
      if (stall !== 6'b000000 || flush !== 1'b0) begin
         errors++;
         $display("FAIL eret_mask stall=%b flush=%b want 000000/0", stall, flush);
      end
      tick();
      drive(1, 0, 0, 0, 0, 0);
      checks++;
      if (stall !== 6'b000111) begin
         errors++;
         $display("FAIL eret_unmask got %b want 000111", stall);
      end
      tick();
   endtask

   task automatic test_watchdog();
      do_reset();
      for (int i = 1; i <= 6; i++) begin
         drive(0, 0, 1, 0, 0, 0);
         tick();
         checks++;
         if (stall_timeout !== (i >= TO)) begin
            errors++;
            $display("FAIL wd_flag edge%0d got %b want %b", i, stall_timeout, i >= TO);
         end
      end
      drive(0, 0, 0, 0, 0, 0);
      tick();
      checks++;
      if (stall_timeout !== 1'b1) begin
         errors++;
         $display("FAIL wd_sticky got %b want 1", stall_timeout);
      end
      drive(0, 0, 0, 1, 32'd3, 0);
      tick();
      checks++;
      if (stall_timeout !== 1'b0) begin
         errors++;
         $display("FAIL wd_clear got %b want 0", stall_timeout);
      end
      // reset in the middle of a stall, between clock edges
      drive(0, 0, 1, 0, 0, 0);
      tick();
      drive(0, 0, 1, 0, 0, 0);
      rst = 1'b0;
      #1;
      checks++;
      if (stall !== 6'b0 || stall_cnt !== 32'h0 || flush_cnt !== 16'h0 || stall_timeout !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_stall stall=%b scnt=%0d fcnt=%0d to=%b want all 0", stall, stall_cnt, flush_cnt, stall_timeout);
      end
      rst = 1'b1;
      drive(0, 0, 0, 1, 32'd7, 0);
      rst = 1'b0;
      #1;
      checks++;
      if (flush !== 1'b0 || new_pc !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_flush flush=%b new_pc=%h want 0/0", flush, new_pc);
      end
      model_reset();
      tick();
      rst = 1'b1;
      #1;
   endtask

   task automatic test_random();
      int errs_before;
      logic [31:0] typ;
      do_reset();
      errs_before = errors;
      for (int i = 0; i < 600; i++) begin
         typ = ($urandom_range(0, 3) == 0) ? 32'hE : 32'($urandom_range(0, 31));
         drive($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 15) == 0, typ, $urandom);
         checks++;
         if (stall !== e_stall || flush !== e_flush || new_pc !== e_pc) begin
            errors++;
            if (errors - errs_before < 10)
               $display("FAIL rand_comb cyc%0d stall=%b/%b flush=%b/%b new_pc=%h/%h (got/want)",
                        i, stall, e_stall, flush, e_flush, new_pc, e_pc);
         end
         tick();
         checks++;
         if (stall_cnt !== 32'(m_scnt) || flush_cnt !== 16'(m_fcnt) || stall_timeout !== m_to) begin
            errors++;
            if (errors - errs_before < 10)
               $display("FAIL rand_regs cyc%0d scnt=%0d/%0d fcnt=%0d/%0d to=%b/%b (got/want)",
                        i, stall_cnt, m_scnt, flush_cnt, m_fcnt, stall_timeout, m_to);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ex_stall();
      test_combined();
      test_exception();
      test_eret();
      test_watchdog();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
